// File: rtl/cp0_unit.sv
// CP0 register file: BadVAddr, Count, Compare, Status, Cause, EPC.
// Takes the committed exception/mtc0 bundle, raises exceptions/eret and drives flush/redirect.
module cp0_unit #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        commit_valid,
  input  logic [31:0] commit_pc,
  input  logic        commit_bd,
  input  logic        exc_adel_if,
  input  logic        exc_ri,
  input  logic        exc_sys,
  input  logic        exc_bp,
  input  logic        exc_tr,
  input  logic        exc_ov,
  input  logic        exc_adel_d,
  input  logic        exc_ades,
  input  logic [31:0] data_vaddr,
  input  logic        eret,
  input  logic        cp0_wen,
  input  logic [4:0]  cp0_waddr,
  input  logic [31:0] cp0_wdata,
  input  logic [5:0]  ext_int,
  output logic [31:0] badvaddr,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic [31:0] status,
  output logic [31:0] cause,
  output logic [31:0] epc,
  output logic        flush,
  output logic [31:0] redirect_pc
);

  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  logic [31:0] r_badvaddr, r_count, r_compare, r_status, r_cause, r_epc;
  logic        r_tick;

  logic        w_int_pend;
  logic        w_exc;
  logic [4:0]  w_code;
  logic        w_bad_en;
  logic [31:0] w_bad_addr;
  logic        w_eret;
  logic        w_wen;
  logic        w_count_wr;
  logic        w_compare_wr;
  logic        w_status_wr;
  logic        w_cause_wr;
  logic        w_epc_wr;
  logic [31:0] w_count_next;
  logic        w_ti_next;
  logic [31:0] w_cause_next;
  logic [31:0] w_status_next;

  assign w_int_pend = r_status[0] & ~r_status[1] & (|(r_cause[15:8] & r_status[15:8]));

  always_comb begin
    w_exc      = 1'b0;
    w_code     = 5'd0;
    w_bad_en   = 1'b0;
    w_bad_addr = 32'd0;
    if (commit_valid) begin
      if (w_int_pend) begin
        w_exc  = 1'b1;
        w_code = 5'd0;
      end else if (exc_adel_if) begin
        w_exc      = 1'b1;
        w_code     = 5'd4;
        w_bad_en   = 1'b1;
        w_bad_addr = commit_pc;
      end else if (exc_ri) begin
        w_exc  = 1'b1;
        w_code = 5'd10;
      end else if (exc_sys) begin
        w_exc  = 1'b1;
        w_code = 5'd8;
      end else if (exc_bp) begin
        w_exc  = 1'b1;
        w_code = 5'd9;
      end else if (exc_tr) begin
        w_exc  = 1'b1;
        w_code = 5'd13;
      end else if (exc_ov) begin
        w_exc  = 1'b1;
        w_code = 5'd12;
      end else if (exc_adel_d) begin
        w_exc      = 1'b1;
        w_code     = 5'd4;
        w_bad_en   = 1'b1;
        w_bad_addr = data_vaddr;
      end else if (exc_ades) begin
        w_exc      = 1'b1;
        w_code     = 5'd5;
        w_bad_en   = 1'b1;
        w_bad_addr = data_vaddr;
      end
    end
  end

  // An exception swallows eret/mtc0; eret beats a stray mtc0.
  assign w_eret       = commit_valid & eret & ~w_exc;
  assign w_wen        = commit_valid & cp0_wen & ~eret & ~w_exc;
  assign w_count_wr   = w_wen & (cp0_waddr == 5'd9);
  assign w_compare_wr = w_wen & (cp0_waddr == 5'd11);
  assign w_status_wr  = w_wen & (cp0_waddr == 5'd12);
  assign w_cause_wr   = w_wen & (cp0_waddr == 5'd13);
  assign w_epc_wr     = w_wen & (cp0_waddr == 5'd14);

  assign flush       = ~reset & (w_exc | w_eret);
  assign redirect_pc = reset ? 32'd0 : (w_exc ? EXC_VECTOR : (w_eret ? r_epc : 32'd0));

  // TI only fires when Count actually moves onto Compare, so a held count=compare after reset stays quiet.
  assign w_count_next = w_count_wr ? cp0_wdata : (r_count + {31'd0, r_tick});
  assign w_ti_next    = w_compare_wr ? 1'b0 :
                        (((w_count_wr | r_tick) && (w_count_next == r_compare)) ? 1'b1 : r_cause[30]);

  always_comb begin
    w_cause_next        = r_cause;
    w_cause_next[30]    = w_ti_next;
    w_cause_next[15:10] = {w_ti_next | ext_int[5], ext_int[4:0]};
    if (w_cause_wr) begin
      w_cause_next[9:8] = cp0_wdata[9:8];
    end
    if (w_exc) begin
      w_cause_next[6:2] = w_code;
      if (!r_status[1]) begin
        w_cause_next[31] = commit_bd;
      end
    end
  end

  always_comb begin
    w_status_next = r_status;
    if (w_status_wr) begin
      w_status_next = (STATUS_RESET & ~STATUS_WMASK) | (cp0_wdata & STATUS_WMASK);
    end
    if (w_exc) begin
      w_status_next[1] = 1'b1;
    end else if (w_eret) begin
      w_status_next[1] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_badvaddr <= 32'd0;
      r_count    <= 32'd0;
      r_compare  <= 32'd0;
      r_status   <= STATUS_RESET;
      r_cause    <= 32'd0;
      r_epc      <= 32'd0;
      r_tick     <= 1'b0;
    end else begin
      r_tick   <= ~r_tick;
      r_count  <= w_count_next;
      r_cause  <= w_cause_next;
      r_status <= w_status_next;
      if (w_compare_wr) begin
        r_compare <= cp0_wdata;
      end
      if (w_exc && w_bad_en) begin
        r_badvaddr <= w_bad_addr;
      end
      if (w_exc && !r_status[1]) begin
        r_epc <= commit_bd ? (commit_pc - 32'd4) : commit_pc;
      end else if (w_epc_wr) begin
        r_epc <= cp0_wdata;
      end
    end
  end

  assign badvaddr = r_badvaddr;
  assign count    = r_count;
  assign compare  = r_compare;
  assign status   = r_status;
  assign cause    = r_cause;
  assign epc      = r_epc;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed plus random checking of cp0_unit against a cycle-level reference model.
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        commit_bd;
  logic        exc_adel_if, exc_ri, exc_sys, exc_bp, exc_tr, exc_ov, exc_adel_d, exc_ades;
  logic [31:0] data_vaddr;
  logic        eret;
  logic        cp0_wen;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic [5:0]  ext_int;
  logic [31:0] badvaddr, count, compare, status, cause, epc;
  logic        flush;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  cp0_unit dut (
    .clk(clk), .reset(reset), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_bd(commit_bd), .exc_adel_if(exc_adel_if), .exc_ri(exc_ri), .exc_sys(exc_sys),
    .exc_bp(exc_bp), .exc_tr(exc_tr), .exc_ov(exc_ov), .exc_adel_d(exc_adel_d),
    .exc_ades(exc_ades), .data_vaddr(data_vaddr), .eret(eret), .cp0_wen(cp0_wen),
    .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata), .ext_int(ext_int),
    .badvaddr(badvaddr), .count(count), .compare(compare), .status(status),
    .cause(cause), .epc(epc), .flush(flush), .redirect_pc(redirect_pc)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_cycle  = 0;

  // Reference model state
  logic [31:0] m_badv, m_count, m_compare, m_status, m_cause, m_epc;
  logic        m_tick;
  logic        obs_flush;
  logic [31:0] obs_redirect;

  int exc_codes [9] = '{0, 4, 10, 8, 9, 13, 12, 4, 5};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, n_cycle);
    end
  endtask

  // Index into the priority list of the exception taken this cycle, or -1.
  function automatic int model_exc();
    bit flags [9];
    bit ip;
    ip = m_status[0] && !m_status[1] && ((m_cause[15:8] & m_status[15:8]) != 8'd0);
    flags = '{ip, exc_adel_if, exc_ri, exc_sys, exc_bp, exc_tr, exc_ov, exc_adel_d, exc_ades};
    if (!commit_valid) return -1;
    for (int i = 0; i < 9; i++) begin
      if (flags[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_update(input int idx, input bit took_eret);
    bit          wen, cnt_wr, ti;
    logic [31:0] new_count;
    logic [31:0] wmask;
    bit          old_exl;
    if (reset) begin
      m_badv = 0; m_count = 0; m_compare = 0; m_cause = 0; m_epc = 0;
      m_status = 32'h0040_0000; m_tick = 0;
      return;
    end
    wmask   = 32'h0000_FF03;
    old_exl = m_status[1];
    wen     = commit_valid && cp0_wen && !eret && (idx < 0);
    cnt_wr  = wen && (cp0_waddr == 9);
    new_count = cnt_wr ? cp0_wdata : (m_tick ? m_count + 1 : m_count);
    ti = m_cause[30];
    if (wen && cp0_waddr == 11) begin
      m_compare = cp0_wdata;
      ti = 0;
    end else if ((cnt_wr || m_tick) && new_count == m_compare) begin
      ti = 1;
    end
    m_count = new_count;
    m_tick  = !m_tick;
    m_cause[30]    = ti;
    m_cause[15:10] = {ti | ext_int[5], ext_int[4:0]};
    if (wen && cp0_waddr == 13) m_cause[9:8] = cp0_wdata[9:8];
    if (wen && cp0_waddr == 12) m_status = (32'h0040_0000 & ~wmask) | (cp0_wdata & wmask);
    if (wen && cp0_waddr == 14) m_epc = cp0_wdata;
    if (idx >= 0) begin
      m_cause[6:2] = exc_codes[idx][4:0];
      m_status[1]  = 1'b1;
      if (!old_exl) begin
        m_epc = commit_bd ? commit_pc - 4 : commit_pc;
        m_cause[31] = commit_bd;
      end
      if (idx == 1) m_badv = commit_pc;
      if (idx == 7 || idx == 8) m_badv = data_vaddr;
    end else if (took_eret) begin
      m_status[1] = 1'b0;
    end
  endtask

  task automatic clear_inputs();
    commit_valid = 0; commit_pc = 0; commit_bd = 0;
    exc_adel_if = 0; exc_ri = 0; exc_sys = 0; exc_bp = 0; exc_tr = 0; exc_ov = 0;
    exc_adel_d = 0; exc_ades = 0; data_vaddr = 0; eret = 0;
    cp0_wen = 0; cp0_waddr = 0; cp0_wdata = 0; ext_int = 0;
  endtask

  // One clock with the currently driven inputs; checks flush before the edge, state after.
  task automatic step();
    int          idx;
    bit          took_eret, exp_flush;
    logic [31:0] exp_redir;
    #1;
    idx       = reset ? -1 : model_exc();
    took_eret = !reset && commit_valid && eret && (idx < 0);
    exp_flush = (idx >= 0) || took_eret;
    exp_redir = (idx >= 0) ? 32'hBFC0_0380 : m_epc;
    obs_flush    = flush;
    obs_redirect = redirect_pc;
    chk("flush", {31'd0, flush}, {31'd0, exp_flush});
    if (exp_flush) chk("redirect_pc", redirect_pc, exp_redir);
    @(posedge clk);
    model_update(idx, took_eret);
    #1;
    n_cycle++;
    chk("badvaddr", badvaddr, m_badv);
    chk("count", count, m_count);
    chk("compare", compare, m_compare);
    chk("status", status, m_status);
    chk("cause", cause, m_cause);
    chk("epc", epc, m_epc);
    $display("cyc %0d rst=%0b cv=%0b pc=%08h flush=%0b cnt=%08h st=%08h ca=%08h epc=%08h",
             n_cycle, reset, commit_valid, commit_pc, obs_flush, count, status, cause, epc);
  endtask

  task automatic idle();
    clear_inputs();
    step();
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    clear_inputs();
    commit_valid = 1; commit_pc = 32'hBFC0_0000; cp0_wen = 1; cp0_waddr = addr; cp0_wdata = data;
    step();
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    m_badv = 0; m_count = 0; m_compare = 0; m_cause = 0; m_epc = 0; m_status = 0; m_tick = 0;
    @(posedge clk);
    #1;
    step();
    step();
    reset = 0;

    // 1: idle after reset
    for (int i = 0; i < 10; i++) idle();
    chk("tp1_count", count, 32'd5);
    chk("tp1_status", status, 32'h0040_0000);
    chk("tp1_cause", cause, 32'd0);

    // 2: timer match, then interrupt taken
    mtc0(5'd11, 32'd3);
    mtc0(5'd9, 32'd0);
    for (int i = 0; i < 8; i++) idle();
    chk("tp2_ti", {31'd0, cause[30]}, 32'd1);
    chk("tp2_ip7", {31'd0, cause[15]}, 32'd1);
    mtc0(5'd12, 32'h0000_8001);
    clear_inputs(); commit_valid = 1; commit_pc = 32'hBFC0_0100;
    step();
    chk("tp2_flush", {31'd0, obs_flush}, 32'd1);
    chk("tp2_redirect", obs_redirect, 32'hBFC0_0380);
    chk("tp2_exccode", {27'd0, cause[6:2]}, 32'd0);
    chk("tp2_epc", epc, 32'hBFC0_0100);
    chk("tp2_exl", {31'd0, status[1]}, 32'd1);

    // 3: store address error in a delay slot
    mtc0(5'd12, 32'd0);
    clear_inputs(); commit_valid = 1; commit_pc = 32'hBFC0_0204; commit_bd = 1;
    exc_ades = 1; data_vaddr = 32'h8000_0003;
    step();
    chk("tp3_badv", badvaddr, 32'h8000_0003);
    chk("tp3_epc", epc, 32'hBFC0_0200);
    chk("tp3_bd", {31'd0, cause[31]}, 32'd1);
    chk("tp3_exccode", {27'd0, cause[6:2]}, 32'd5);

    // 4: priority and nested exception
    mtc0(5'd12, 32'd0);
    clear_inputs(); commit_valid = 1; commit_pc = 32'hBFC0_0300; exc_ri = 1; exc_ov = 1;
    step();
    chk("tp4_exccode_ri", {27'd0, cause[6:2]}, 32'd10);
    chk("tp4_epc", epc, 32'hBFC0_0300);
    clear_inputs(); commit_valid = 1; commit_pc = 32'hBFC0_0400; exc_sys = 1;
    step();
    chk("tp4_epc_kept", epc, 32'hBFC0_0300);
    chk("tp4_exccode_sys", {27'd0, cause[6:2]}, 32'd8);

    // 5: eret, then eret suppressed by breakpoint
    mtc0(5'd14, 32'hBFC0_0010);
    clear_inputs(); commit_valid = 1; commit_pc = 32'hBFC0_0500; eret = 1;
    step();
    chk("tp5_flush", {31'd0, obs_flush}, 32'd1);
    chk("tp5_redirect", obs_redirect, 32'hBFC0_0010);
    chk("tp5_exl0", {31'd0, status[1]}, 32'd0);
    clear_inputs(); commit_valid = 1; commit_pc = 32'hBFC0_0600; eret = 1; exc_bp = 1;
    step();
    chk("tp5_redirect_bp", obs_redirect, 32'hBFC0_0380);
    chk("tp5_exl1", {31'd0, status[1]}, 32'd1);

    // 6: cause write mask, count override, reset during exception
    mtc0(5'd13, 32'hFFFF_FFFF);
    chk("tp6_ipsw", {30'd0, cause[9:8]}, 32'd3);
    if (!m_tick) idle();
    mtc0(5'd9, 32'h0000_0100);
    chk("tp6_count", count, 32'h0000_0100);
    clear_inputs(); reset = 1; commit_valid = 1; commit_pc = 32'hBFC0_0700; exc_sys = 1;
    step();
    chk("tp6_rst_flush", {31'd0, obs_flush}, 32'd0);
    chk("tp6_rst_status", status, 32'h0040_0000);
    chk("tp6_rst_epc", epc, 32'd0);
    chk("tp6_rst_cause", cause, 32'd0);
    reset = 0;

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      int          sel;
      logic [4:0]  addrs [7];
      clear_inputs();
      addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'($urandom_range(0, 31))};
      reset        = ($urandom_range(0, 199) == 0);
      commit_valid = ($urandom_range(0, 3) != 0);
      commit_pc    = $urandom & 32'hFFFF_FFFC;
      commit_bd    = $urandom_range(0, 1);
      exc_adel_if  = ($urandom_range(0, 24) == 0);
      exc_ri       = ($urandom_range(0, 24) == 0);
      exc_sys      = ($urandom_range(0, 24) == 0);
      exc_bp       = ($urandom_range(0, 24) == 0);
      exc_tr       = ($urandom_range(0, 24) == 0);
      exc_ov       = ($urandom_range(0, 24) == 0);
      exc_adel_d   = ($urandom_range(0, 24) == 0);
      exc_ades     = ($urandom_range(0, 24) == 0);
      data_vaddr   = $urandom;
      eret         = ($urandom_range(0, 9) == 0);
      cp0_wen      = ($urandom_range(0, 2) == 0);
      sel          = $urandom_range(0, 6);
      cp0_waddr    = addrs[sel];
      cp0_wdata    = $urandom;
      if (cp0_waddr == 5'd11 && $urandom_range(0, 1) == 1) cp0_wdata = m_count + $urandom_range(1, 6);
      if (cp0_waddr == 5'd12 && $urandom_range(0, 2) != 0) cp0_wdata = cp0_wdata & 32'hFFFF_FFFE;
      ext_int      = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'd0;
      step();
    end
    reset = 0;
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
